// File: rtl/uart_pkg.sv
// uart_pkg: arbiter FSM states, header magic and index-width helper shared by the UART TX arbiter
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_WAIT_HI, S_WAIT_LO} arb_state_t;
  localparam logic [3:0] HDR_MAGIC = 4'hA;
  localparam int DATA_BITS_DEF = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: first valid requester at or after the round-robin pointer, wrapping modulo NUM_REQ
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IW-1:0]      i_rr_ptr,
  output logic               o_any_valid,
  output logic [IW-1:0]      o_winner
);
  logic [IW:0] w_sum;
  always_comb begin
    o_any_valid = |i_req_valid;
    o_winner = '0;
    w_sum = '0;
    // scan farthest offset first so the nearest valid index is the one left standing
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_rr_ptr} + (IW+1)'(k);
      w_sum = (w_sum >= (IW+1)'(NUM_REQ)) ? w_sum - (IW+1)'(NUM_REQ) : w_sum;
      if (i_req_valid[w_sum[IW-1:0]]) o_winner = w_sum[IW-1:0];
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one uart_tx among NUM_REQ byte streams.
// Define UART_TX_ARB_TAG_EN to prefix every packet with a {HDR_MAGIC, grant_id} header byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = DATA_BITS_DEF,
  localparam int IW       = idx_w(NUM_REQ)
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]           i_req_last,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [DATA_BITS-1:0]         o_tx_data,
  output logic                         o_tx_start,
  input  logic                         i_tx_busy,
  output logic                         o_grant_valid,
  output logic [IW-1:0]                o_grant_id
);
  arb_state_t           r_state, w_state_nx;
  logic [IW-1:0]        r_rr_ptr, w_rr_ptr_nx, r_grant_id, w_grant_id_nx, w_winner;
  logic                 r_grant_valid, w_grant_valid_nx, r_tx_start, w_tx_start_nx;
  logic                 r_last, w_last_nx, w_any;
  logic [DATA_BITS-1:0] r_tx_data, w_tx_data_nx;
  logic [NUM_REQ-1:0]   r_req_ready, w_req_ready_nx;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .i_req_valid(i_req_valid),
    .i_rr_ptr   (r_rr_ptr),
    .o_any_valid(w_any),
    .o_winner   (w_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rr_ptr <= '0;
      r_grant_id <= '0;
      r_grant_valid <= 1'b0;
      r_tx_data <= '0;
      r_tx_start <= 1'b0;
      r_req_ready <= '0;
      r_last <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_rr_ptr <= w_rr_ptr_nx;
      r_grant_id <= w_grant_id_nx;
      r_grant_valid <= w_grant_valid_nx;
      r_tx_data <= w_tx_data_nx;
      r_tx_start <= w_tx_start_nx;
      r_req_ready <= w_req_ready_nx;
      r_last <= w_last_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_rr_ptr_nx = r_rr_ptr;
    w_grant_id_nx = r_grant_id;
    w_grant_valid_nx = r_grant_valid;
    w_tx_data_nx = r_tx_data;
    w_tx_start_nx = 1'b0;
    w_req_ready_nx = '0;
    w_last_nx = r_last;
    case (r_state)
      S_IDLE: if (w_any && !i_tx_busy) begin
        w_grant_id_nx = w_winner;
        w_grant_valid_nx = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
        w_state_nx = S_HDR;
`else
        w_state_nx = S_LOAD;
`endif
      end
`ifdef UART_TX_ARB_TAG_EN
      S_HDR: begin
        w_tx_data_nx = DATA_BITS'({HDR_MAGIC, 4'(r_grant_id)});
        w_tx_start_nx = 1'b1;
        w_last_nx = 1'b0;
        w_state_nx = S_WAIT_HI;
      end
`endif
      S_LOAD: if (i_req_valid[r_grant_id]) begin
        w_tx_data_nx = i_req_data[r_grant_id*DATA_BITS +: DATA_BITS];
        w_tx_start_nx = 1'b1;
        w_req_ready_nx[r_grant_id] = 1'b1;
        w_last_nx = i_req_last[r_grant_id];
        w_state_nx = S_WAIT_HI;
      end
      S_WAIT_HI: w_state_nx = i_tx_busy ? S_WAIT_LO : S_WAIT_HI;
      S_WAIT_LO: if (!i_tx_busy) begin
        // release after the last byte leaves the wire; the winner drops to lowest priority
        w_state_nx = r_last ? S_IDLE : S_LOAD;
        w_grant_valid_nx = !r_last;
        w_rr_ptr_nx = !r_last ? r_rr_ptr :
                      (r_grant_id == IW'(NUM_REQ-1)) ? '0 : r_grant_id + 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign o_req_ready = r_req_ready;
  assign o_tx_data = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_id = r_grant_id;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a packet-level round-robin model
module tb_uart_tx_arbiter;
  localparam int NR = 4, DW = 8, IW = 2;
`ifdef UART_TX_ARB_TAG_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  typedef struct packed {logic [DW-1:0] data; logic [IW-1:0] id; logic [NR-1:0] ready; logic gv;} ev_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [NR-1:0] req_valid = '0, req_last = '0, req_ready, hold = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [DW-1:0] tx_data;
  logic tx_start, grant_valid, tx_busy;
  logic [IW-1:0] grant_id;
  logic m_busy = 1'b0, ext_busy = 1'b0;
  logic armed = 1'b0, chk_pend = 1'b0, chk_last = 1'b0, cur_last = 1'b0;
  logic [DW:0] q [NR][$];
  logic [DW:0] mb [NR][$];
  int mpk_n [NR];
  ev_t exp_q [$];
  int total = 0, bad = 0, n_start = 0, m_ptr = 0, fcnt = 0, flen_lo = 1, flen_hi = 6;

  assign tx_busy = m_busy | ext_busy;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_busy(tx_busy), .o_grant_valid(grant_valid), .o_grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic add_byte(input int i, input logic [DW-1:0] d, input logic l);
    q[i].push_back({l, d});
    mb[i].push_back({l, d});
    if (l) mpk_n[i]++;
  endtask

  // reference: whole packets granted in round-robin order, winner then becomes lowest priority
  task automatic model_flush();
    int w;
    logic [DW:0] b;
    forever begin
      w = -1;
      for (int k = 0; k < NR; k++) if (w < 0 && mpk_n[(m_ptr + k) % NR] > 0) w = (m_ptr + k) % NR;
      if (w < 0) break;
      if (HDR == 1) exp_q.push_back('{data: {4'hA, 4'(w)}, id: IW'(w), ready: '0, gv: 1'b1});
      do begin
        b = mb[w].pop_front();
        exp_q.push_back('{data: b[DW-1:0], id: IW'(w), ready: NR'(1) << w, gv: 1'b1});
      end while (!b[DW]);
      mpk_n[w]--;
      m_ptr = (w + 1) % NR;
    end
  endtask

  function automatic bit q_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_done(input string tag);
    int n = 0;
    while (n < 4000 && !(exp_q.size() == 0 && !tx_busy && !grant_valid && q_empty())) begin
      @(posedge clk); #2;
      n++;
    end
    chk(tag, 32'(n < 4000), 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_starts(input int n, input string tag);
    int c = 0;
    while (n_start < n && c < 2000) begin
      @(posedge clk); #2;
      c++;
    end
    chk(tag, 32'(n_start >= n), 1);
  endtask

  // uart_tx model, event scoreboard and requester drivers, all sampled 1 time unit after the edge
  initial forever begin
    ev_t got_ev, want_ev;
    logic [DW:0] hd;
    @(posedge clk); #1;
    if (reset) begin
      for (int i = 0; i < NR; i++) q[i].delete();
      exp_q.delete();
      armed = 1'b0;
      chk_pend = 1'b0;
    end
    if (chk_pend) begin
      chk_pend = 1'b0;
      chk("gv_after_busy_fall", 32'(grant_valid), 32'(!chk_last));
    end
    if (tx_start) begin
      chk("one_start_per_frame", 32'(tx_busy), 0);
      chk("start_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        got_ev = '{data: tx_data, id: grant_id, ready: req_ready, gv: grant_valid};
        want_ev = exp_q.pop_front();
        chk("tx_event", 32'(got_ev), 32'(want_ev));
      end
      cur_last = (req_ready != '0 && q[grant_id].size() > 0) ? q[grant_id][0][DW] : 1'b0;
      armed = 1'b1;
      m_busy = 1'b1;
      fcnt = $urandom_range(flen_hi, flen_lo);
      n_start++;
    end else begin
      chk("ready_only_with_start", 32'(req_ready), 0);
      if (m_busy) begin
        fcnt--;
        if (fcnt <= 0) begin
          m_busy = 1'b0;
          chk_pend = armed;
          chk_last = cur_last;
          armed = 1'b0;
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
      hd = (q[i].size() > 0) ? q[i][0] : '0;
      req_valid[i] = (q[i].size() > 0) && !hold[i];
      req_last[i] = hd[DW];
      req_data[i*DW +: DW] = hd[DW-1:0];
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < NR; i++) mpk_n[i] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_grant_valid", 32'(grant_valid), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    reset = 1'b0;
    @(posedge clk); #2;
    add_byte(0, 8'hA0, 1'b1); add_byte(1, 8'hB1, 1'b1); add_byte(3, 8'hD3, 1'b1);
    model_flush();
    wait_done("t2_burst_done");
    add_byte(0, 8'hA4, 1'b1); add_byte(1, 8'hB5, 1'b1);
    model_flush();
    wait_done("t2_rereq_done");
    add_byte(2, 8'h11, 1'b0); add_byte(2, 8'h22, 1'b0); add_byte(2, 8'h33, 1'b1);
    model_flush();
    wait_done("t1_done");
    add_byte(0, 8'h0F, 1'b1); add_byte(3, 8'h3F, 1'b1);
    model_flush();
    wait_done("ptr_probe_done");
    base = n_start;
    add_byte(1, 8'h71, 1'b0); add_byte(1, 8'h72, 1'b0); add_byte(1, 8'h73, 1'b1);
    model_flush();
    wait_starts(base + 1, "t3_first_start");
    hold[1] = 1'b1;
    add_byte(0, 8'h70, 1'b1);
    model_flush();
    repeat (40) @(posedge clk);
    #2;
    chk("t3_no_start", 32'(n_start), 32'(base + 1));
    chk("t3_grant_held", 32'({grant_valid, grant_id}), 32'({1'b1, 2'd1}));
    hold[1] = 1'b0;
    wait_done("t3_done");
    ext_busy = 1'b1;
    base = n_start;
    add_byte(1, 8'h44, 1'b1);
    model_flush();
    repeat (20) @(posedge clk);
    #2;
    chk("t4_no_start", 32'(n_start), 32'(base));
    chk("t4_no_grant", 32'(grant_valid), 0);
    ext_busy = 1'b0;
    wait_done("t4_done");
    flen_lo = 6; flen_hi = 6;
    base = n_start;
    add_byte(2, 8'h51, 1'b0); add_byte(2, 8'h52, 1'b0); add_byte(2, 8'h53, 1'b0); add_byte(2, 8'h54, 1'b1);
    model_flush();
    wait_starts(base + 2 + HDR, "t5_second_byte");
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_outputs", 32'({tx_start, req_ready, grant_valid, grant_id, tx_data}), 0);
    for (int i = 0; i < NR; i++) begin
      mb[i].delete();
      mpk_n[i] = 0;
    end
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    add_byte(3, 8'h63, 1'b1); add_byte(1, 8'h61, 1'b1);
    model_flush();
    wait_done("t5_done");
    flen_lo = 1; flen_hi = 6;
    add_byte(3, 8'h55, 1'b1);
    model_flush();
    wait_done("t6_done");
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++) begin
        int np, len;
        np = $urandom_range(2, 0);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
        end
      end
      model_flush();
      wait_done("rand_done");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
